// File: rtl/aclk_keybuf_pkg.sv
// aclk_pkg: shared types and constants for the alarm-clock key-entry path.
// Consumed by aclk_keybuf and aclk_idle_timer.
package aclk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    FULL  = 2'd2
  } keybuf_state_e;

  localparam int ACLK_MAX_DIGIT = 9;
  localparam int ACLK_DIGIT_W   = 4;

  // State is a pure function of how many digits are held.
  function automatic keybuf_state_e aclk_fill_state(
    input int unsigned cnt,
    input int unsigned n
  );
    keybuf_state_e s;
    if (cnt == 0)
      s = IDLE;
    else if (cnt >= n)
      s = FULL;
    else
      s = ENTRY;
    return s;
  endfunction

endpackage

// File: rtl/aclk_keybuf_idle_timer.sv
// aclk_idle_timer: saturating idle counter with clear/enable/expire.
// o_expire is high during the cycle the count sits at CYCLES-1 while enabled.
module aclk_idle_timer
  import aclk_pkg::*;
#(
  parameter int CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          w_at_last;

  assign w_at_last = (r_cnt == LAST);
  assign o_expire  = i_en & w_at_last;

  // Saturates at LAST so a suppressed expiry fires on the next free cycle.
  always_ff @(posedge clk) begin
    if (rst || i_clr)
      r_cnt <= '0;
    else if (i_en && !w_at_last)
      r_cnt <= r_cnt + CW'(1);
  end

endmodule

// File: rtl/aclk_keybuf.sv
// aclk_keybuf: parametrised key-entry buffer (shift/backspace/clear/timeout).
// Optional macro ACLK_KEYBUF_RANGE_CHK_EN rejects shifted keys above 9.
module aclk_keybuf
  import aclk_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int DIGIT_W        = ACLK_DIGIT_W,
  parameter int LOCK_WHEN_FULL = 0,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             shift,
  input  logic [DIGIT_W-1:0]               key,
  input  logic                             backspace,
  input  logic                             clear,
  output logic [NUM_DIGITS*DIGIT_W-1:0]    key_buffer,
  output logic [$clog2(NUM_DIGITS+1)-1:0]  digit_count,
  output logic                             full,
  output logic                             reject,
  output logic                             timeout
);

  localparam int BW = NUM_DIGITS * DIGIT_W;
  localparam int CW = $clog2(NUM_DIGITS + 1);

  logic [BW-1:0]  r_buf;
  logic [CW-1:0]  r_cnt;
  keybuf_state_e  r_state;
  logic           r_reject;
  logic           r_timeout;

  logic [BW-1:0]  w_buf_nxt;
  logic [CW-1:0]  w_cnt_nxt;
  logic           w_rej_nxt;
  logic           w_to_nxt;
  logic           w_evt;
  logic           w_key_bad;
  logic           w_expire;
  logic [BW-1:0]  w_buf_shl;
  logic [BW-1:0]  w_buf_shr;

`ifdef ACLK_KEYBUF_RANGE_CHK_EN
  assign w_key_bad = (32'(key) > 32'(ACLK_MAX_DIGIT));
`else
  assign w_key_bad = 1'b0;
`endif

  assign w_buf_shl = {r_buf[BW-DIGIT_W-1:0], key};
  assign w_buf_shr = r_buf >> DIGIT_W;

  always_comb begin
    w_buf_nxt = r_buf;
    w_cnt_nxt = r_cnt;
    w_rej_nxt = 1'b0;
    w_to_nxt  = 1'b0;
    w_evt     = 1'b0;
    if (clear) begin
      w_buf_nxt = '0;
      w_cnt_nxt = '0;
      w_evt     = 1'b1;
    end else if (shift) begin
      if (w_key_bad) begin
        w_rej_nxt = 1'b1;
      end else if (r_state == FULL) begin
        if (LOCK_WHEN_FULL != 0) begin
          w_rej_nxt = 1'b1;
        end else begin
          w_buf_nxt = w_buf_shl;
          w_evt     = 1'b1;
        end
      end else begin
        w_buf_nxt = w_buf_shl;
        w_cnt_nxt = r_cnt + CW'(1);
        w_evt     = 1'b1;
      end
    end else if (backspace) begin
      if (r_state == IDLE) begin
        w_rej_nxt = 1'b1;
      end else begin
        w_buf_nxt = w_buf_shr;
        w_cnt_nxt = r_cnt - CW'(1);
        w_evt     = 1'b1;
      end
    end else if (w_expire) begin
      w_buf_nxt = '0;
      w_cnt_nxt = '0;
      w_to_nxt  = 1'b1;
    end
  end

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_tmr
      logic w_tmr_clr;
      logic w_tmr_en;
      // A range-rejected key freezes the idle count rather than advancing it.
      assign w_tmr_clr = w_evt | w_to_nxt | (r_state == IDLE);
      assign w_tmr_en  = (r_state != IDLE) & ~(shift & ~clear & w_key_bad);
      aclk_idle_timer #(
        .CYCLES (TIMEOUT_CYCLES)
      ) u_idle_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_tmr_clr),
        .i_en     (w_tmr_en),
        .o_expire (w_expire)
      );
    end else begin : g_no_tmr
      logic w_unused_evt;
      assign w_unused_evt = w_evt;
      assign w_expire     = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf     <= '0;
      r_cnt     <= '0;
      r_state   <= IDLE;
      r_reject  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_buf     <= w_buf_nxt;
      r_cnt     <= w_cnt_nxt;
      r_state   <= aclk_fill_state(32'(w_cnt_nxt), NUM_DIGITS);
      r_reject  <= w_rej_nxt;
      r_timeout <= w_to_nxt;
    end
  end

  assign key_buffer  = r_buf;
  assign digit_count = r_cnt;
  assign full        = (r_state == FULL);
  assign reject      = r_reject;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_aclk_keybuf.sv
// tb_aclk_keybuf: checks two aclk_keybuf builds (overwrite+timeout, lock)
// against a digit-queue reference model, plus directed scenarios.
module tb_aclk_keybuf;

`ifdef ACLK_KEYBUF_RANGE_CHK_EN
  localparam bit RNG = 1'b1;
`else
  localparam bit RNG = 1'b0;
`endif

  localparam int LOCK [2] = '{0, 1};
  localparam int TMO  [2] = '{8, 0};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        shift = 1'b0;
  logic        backspace = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  key = 4'h0;

  logic [15:0] kb [2];
  logic [2:0]  dc [2];
  logic        fu [2];
  logic        rj [2];
  logic        to [2];

  int n_chk = 0;
  int n_fail = 0;

  logic [3:0] mq [2][$];
  int         age [2];
  logic       m_rej [2];
  logic       m_to [2];

  always #5 clk = ~clk;

  aclk_keybuf #(
    .NUM_DIGITS(4), .DIGIT_W(4), .LOCK_WHEN_FULL(0), .TIMEOUT_CYCLES(8)
  ) dut0 (
    .clk(clk), .rst(rst), .shift(shift), .key(key),
    .backspace(backspace), .clear(clear),
    .key_buffer(kb[0]), .digit_count(dc[0]), .full(fu[0]),
    .reject(rj[0]), .timeout(to[0])
  );

  aclk_keybuf #(
    .NUM_DIGITS(4), .DIGIT_W(4), .LOCK_WHEN_FULL(1), .TIMEOUT_CYCLES(0)
  ) dut1 (
    .clk(clk), .rst(rst), .shift(shift), .key(key),
    .backspace(backspace), .clear(clear),
    .key_buffer(kb[1]), .digit_count(dc[1]), .full(fu[1]),
    .reject(rj[1]), .timeout(to[1])
  );

  // Reference: a FIFO of digits, oldest at the front, plus an idle age.
  function automatic void mstep(input int k);
    m_rej[k] = 1'b0;
    m_to[k]  = 1'b0;
    if (rst) begin
      mq[k].delete();
      age[k] = 0;
    end else if (clear) begin
      mq[k].delete();
      age[k] = 0;
    end else if (shift) begin
      if (RNG && key > 4'd9) begin
        m_rej[k] = 1'b1;
      end else if (mq[k].size() == 4 && LOCK[k] != 0) begin
        m_rej[k] = 1'b1;
        if (age[k] < TMO[k] - 1) age[k]++;
      end else begin
        if (mq[k].size() == 4) void'(mq[k].pop_front());
        mq[k].push_back(key);
        age[k] = 0;
      end
    end else if (backspace) begin
      if (mq[k].size() == 0) begin
        m_rej[k] = 1'b1;
      end else begin
        void'(mq[k].pop_back());
        age[k] = 0;
      end
    end else if (TMO[k] > 0 && mq[k].size() > 0) begin
      if (age[k] == TMO[k] - 1) begin
        mq[k].delete();
        age[k] = 0;
        m_to[k] = 1'b1;
      end else begin
        age[k]++;
      end
    end
  endfunction

  function automatic logic [15:0] mpack(input int k);
    logic [15:0] v;
    v = 16'h0;
    for (int i = 0; i < mq[k].size(); i++)
      v = v * 16 + 16'(mq[k][i]);
    return v;
  endfunction

  task automatic step();
    for (int k = 0; k < 2; k++) mstep(k);
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] v);
    shift = 1'b1;
    key = v;
    step();
    shift = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (kb[k] !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_buf[%0d]: got %h want 0000", k, kb[k]);
      end
      n_chk++;
      if ({dc[k], fu[k], rj[k], to[k]} !== 6'b0) begin
        n_fail++;
        $display("FAIL reset_flags[%0d]: got %b want 000000", k,
                 {dc[k], fu[k], rj[k], to[k]});
      end
    end
  endtask

  task automatic test_fill();
    push(4'h1); push(4'h2); push(4'h3); push(4'h4);
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if ({kb[k], dc[k], fu[k]} !== {16'h1234, 3'd4, 1'b1}) begin
        n_fail++;
        $display("FAIL fill[%0d]: got %h/%0d/%b want 1234/4/1", k,
                 kb[k], dc[k], fu[k]);
      end
    end
  endtask

  task automatic test_full_shift();
    push(4'h5);
    n_chk++;
    if ({kb[0], rj[0]} !== {16'h2345, 1'b0}) begin
      n_fail++;
      $display("FAIL full_overwrite: got %h rej=%b want 2345 rej=0", kb[0], rj[0]);
    end
    n_chk++;
    if ({kb[1], dc[1], rj[1]} !== {16'h1234, 3'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL full_lock: got %h/%0d rej=%b want 1234/4 rej=1",
               kb[1], dc[1], rj[1]);
    end
    step();
    n_chk++;
    if ({kb[1], rj[1]} !== {16'h1234, 1'b0}) begin
      n_fail++;
      $display("FAIL lock_pulse: got %h rej=%b want 1234 rej=0", kb[1], rj[1]);
    end
  endtask

  task automatic test_backspace();
    logic [15:0] exp_b [4];
    exp_b = '{16'h0123, 16'h0012, 16'h0001, 16'h0000};
    do_clear();
    push(4'h1); push(4'h2); push(4'h3); push(4'h4);
    for (int i = 0; i < 4; i++) begin
      backspace = 1'b1;
      step();
      backspace = 1'b0;
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if ({kb[k], dc[k], fu[k], rj[k]} !== {exp_b[i], 3'(3 - i), 2'b00}) begin
          n_fail++;
          $display("FAIL bksp%0d[%0d]: got %h/%0d/%b/%b want %h/%0d/0/0", i, k,
                   kb[k], dc[k], fu[k], rj[k], exp_b[i], 3 - i);
        end
      end
    end
    backspace = 1'b1;
    step();
    backspace = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if ({kb[k], dc[k], rj[k]} !== {16'h0, 3'd0, 1'b1}) begin
        n_fail++;
        $display("FAIL bksp_empty[%0d]: got %h/%0d rej=%b want 0000/0 rej=1", k,
                 kb[k], dc[k], rj[k]);
      end
    end
  endtask

  task automatic test_timeout();
    do_clear();
    push(4'h7);
    for (int i = 1; i <= 9; i++) begin
      step();
      n_chk++;
      if ({kb[0], dc[0], to[0]} !==
          {(i >= 8) ? 16'h0 : 16'h7, (i >= 8) ? 3'd0 : 3'd1, i == 8}) begin
        n_fail++;
        $display("FAIL timeout_edge%0d: got %h/%0d to=%b", i, kb[0], dc[0], to[0]);
      end
    end
    n_chk++;
    if ({kb[1], to[1]} !== {16'h7, 1'b0}) begin
      n_fail++;
      $display("FAIL no_timer: got %h to=%b want 0007 to=0", kb[1], to[1]);
    end
    do_clear();
    push(4'h7);
    repeat (7) step();
    push(4'h3);
    n_chk++;
    if ({kb[0], to[0]} !== {16'h73, 1'b0}) begin
      n_fail++;
      $display("FAIL timeout_restart: got %h to=%b want 0073 to=0", kb[0], to[0]);
    end
    repeat (7) step();
    n_chk++;
    if ({kb[0], to[0]} !== {16'h73, 1'b0}) begin
      n_fail++;
      $display("FAIL timeout_early: got %h to=%b want 0073 to=0", kb[0], to[0]);
    end
    step();
    n_chk++;
    if ({kb[0], dc[0], to[0]} !== {16'h0, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL timeout_late: got %h/%0d to=%b want 0000/0 to=1",
               kb[0], dc[0], to[0]);
    end
  endtask

  task automatic test_clear_shift();
    do_clear();
    push(4'h1); push(4'h2);
    clear = 1'b1; shift = 1'b1; key = 4'h9;
    step();
    clear = 1'b0; shift = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if ({kb[k], dc[k], rj[k]} !== {16'h0, 3'd0, 1'b0}) begin
        n_fail++;
        $display("FAIL clear_prio[%0d]: got %h/%0d rej=%b want 0000/0 rej=0", k,
                 kb[k], dc[k], rj[k]);
      end
    end
  endtask

  task automatic test_rst_mid();
    push(4'h1); push(4'h2);
    rst = 1'b1; shift = 1'b1; key = 4'h5; backspace = 1'b1;
    step();
    rst = 1'b0; shift = 1'b0; backspace = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if ({kb[k], dc[k], fu[k], rj[k], to[k]} !== 22'b0) begin
        n_fail++;
        $display("FAIL rst_mid[%0d]: got %h/%0d/%b/%b/%b want all 0", k,
                 kb[k], dc[k], fu[k], rj[k], to[k]);
      end
    end
  endtask

`ifdef ACLK_KEYBUF_RANGE_CHK_EN
  task automatic test_range();
    do_clear();
    push(4'h1); push(4'h2);
    push(4'hA);
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if ({kb[k], dc[k], rj[k]} !== {16'h0012, 3'd2, 1'b1}) begin
        n_fail++;
        $display("FAIL range[%0d]: got %h/%0d rej=%b want 0012/2 rej=1", k,
                 kb[k], dc[k], rj[k]);
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      if ((c % 60) >= 47) begin
        rst = 1'b0; clear = 1'b0; shift = 1'b0; backspace = 1'b0;
      end else begin
        rst       = ($urandom_range(0, 99) < 1);
        clear     = ($urandom_range(0, 99) < 4);
        shift     = ($urandom_range(0, 99) < 40);
        backspace = ($urandom_range(0, 99) < 25);
      end
      key = 4'($urandom_range(0, 15));
      step();
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if ({kb[k], dc[k], fu[k], rj[k], to[k]} !==
            {mpack(k), 3'(mq[k].size()), mq[k].size() == 4, m_rej[k], m_to[k]}) begin
          n_fail++;
          $display("FAIL random c%0d[%0d]: got %h/%0d/%b/%b/%b want %h/%0d/%b/%b/%b",
                   c, k, kb[k], dc[k], fu[k], rj[k], to[k], mpack(k),
                   mq[k].size(), mq[k].size() == 4, m_rej[k], m_to[k]);
        end
      end
    end
    rst = 1'b0; clear = 1'b0; shift = 1'b0; backspace = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      age[k] = 0;
      m_rej[k] = 1'b0;
      m_to[k] = 1'b0;
    end
    #2;
    test_reset();
    test_fill();
    test_full_shift();
    test_backspace();
    test_timeout();
    test_clear_shift();
    test_rst_mid();
`ifdef ACLK_KEYBUF_RANGE_CHK_EN
    test_range();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
